// File: rtl/prf_write_ctrl_if.sv
// Writeback request channel into the PRF write controller.
// Valid/ready handshake carrying a physical register index and data.
interface prf_write_ctrl_if #(
  parameter int INDEX = 4,
  parameter int WIDTH = 8
);
  logic             wb_valid_i;
  logic             wb_ready_o;
  logic [INDEX-1:0] wb_addr_i;
  logic [WIDTH-1:0] wb_data_i;

  modport master (
    output wb_valid_i,
    output wb_addr_i,
    output wb_data_i,
    input  wb_ready_o
  );

  modport slave (
    input  wb_valid_i,
    input  wb_addr_i,
    input  wb_data_i,
    output wb_ready_o
  );
endinterface

// File: rtl/prf_write_ctrl.sv
// PRF write-port controller: post-reset init sweep, in-order
// writeback FIFO drain, and forwarding lookup over queued writes.
module prf_write_ctrl #(
  parameter int               DEPTH      = 16,
  parameter int               INDEX      = 4,
  parameter int               WIDTH      = 8,
  parameter int               FIFO_DEPTH = 4,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0,
  localparam int              CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  prf_write_ctrl_if.slave    wb,
  input  logic               reinit_i,
  output logic               init_done_o,
  output logic [CW-1:0]      fifo_count_o,
  input  logic [INDEX-1:0]   rd_addr_i,
  output logic               rd_hit_o,
  output logic [WIDTH-1:0]   rd_data_o,
  output logic [INDEX-1:0]   addrwr_o,
  output logic [WIDTH-1:0]   datawr_o,
  output logic               we_o
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic {
    INIT,
    RUN
  } state_e;

  state_e           state_q, state_d;
  logic [INDEX-1:0] init_ptr_q, init_ptr_d;
  logic             pend_q, pend_d;

  logic [INDEX-1:0] addr_q [FIFO_DEPTH];
  logic [WIDTH-1:0] data_q [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;

  logic             full, empty;
  logic             push, pop;
  logic             we;
  logic [INDEX-1:0] addr;
  logic [WIDTH-1:0] data;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign empty = (count_q == '0);

  assign wb.wb_ready_o = reset_n & ~full & ~pend_q;
  assign push          = wb.wb_valid_i & wb.wb_ready_o;
  assign pop           = (state_q == RUN) & ~empty;

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    pend_d     = pend_q;
    we         = 1'b0;
    addr       = '0;
    data       = '0;
    unique case (state_q)
      INIT: begin
        we         = 1'b1;
        addr       = init_ptr_q;
        data       = INIT_VALUE;
        init_ptr_d = init_ptr_q + INDEX'(1);
        if (init_ptr_q == INDEX'(DEPTH - 1)) begin
          state_d    = RUN;
          init_ptr_d = '0;
        end
      end
      RUN: begin
        pend_d = pend_q | reinit_i;
        if (!empty) begin
          we   = 1'b1;
          addr = addr_q[rd_ptr_q];
          data = data_q[rd_ptr_q];
        end else if (pend_q) begin
          state_d    = INIT;
          init_ptr_d = '0;
          pend_d     = 1'b0;
        end
      end
      default: state_d = INIT;
    endcase
  end

  // Reset must win over the combinational INIT-state write strobe.
  assign we_o        = reset_n & we;
  assign addrwr_o    = reset_n ? addr : '0;
  assign datawr_o    = reset_n ? data : '0;
  assign init_done_o = reset_n & (state_q == RUN);
  assign fifo_count_o = count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= INIT;
      init_ptr_q <= '0;
      pend_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
      pend_q     <= pend_d;
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= wb.wb_addr_i;
      data_q[wr_ptr_q] <= wb.wb_data_i;
    end
  end

  logic [PW:0]      fwd_sum;
  logic [PW-1:0]    fwd_idx;
  logic             hit;
  logic [WIDTH-1:0] fwd_data;

  // Walk oldest to youngest so the last match is the youngest.
  always_comb begin
    fwd_sum  = '0;
    fwd_idx  = '0;
    hit      = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      fwd_sum = {1'b0, rd_ptr_q} + (PW+1)'(i);
      if (fwd_sum >= (PW+1)'(FIFO_DEPTH))
        fwd_sum = fwd_sum - (PW+1)'(FIFO_DEPTH);
      fwd_idx = fwd_sum[PW-1:0];
      if ((CW'(i) < count_q) && (addr_q[fwd_idx] == rd_addr_i)) begin
        hit      = 1'b1;
        fwd_data = data_q[fwd_idx];
      end
    end
  end

  assign rd_hit_o  = hit;
  assign rd_data_o = fwd_data;

endmodule

// File: tb/tb_prf_write_ctrl.sv
// Randomized bench for prf_write_ctrl against a queue-based
// reference model and a behavioural PRF RAM.
module tb_prf_write_ctrl;

  localparam int DEPTH = 16;
  localparam int INDEX = 4;
  localparam int WIDTH = 8;
  localparam int FD    = 4;
  localparam int CW    = $clog2(FD + 1);
  localparam logic [WIDTH-1:0] INIT_V = 8'h00;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  prf_write_ctrl_if #(.INDEX(INDEX), .WIDTH(WIDTH)) wb ();

  logic             reinit_i;
  logic             init_done_o;
  logic [CW-1:0]    fifo_count_o;
  logic [INDEX-1:0] rd_addr_i;
  logic             rd_hit_o;
  logic [WIDTH-1:0] rd_data_o;
  logic [INDEX-1:0] addrwr_o;
  logic [WIDTH-1:0] datawr_o;
  logic             we_o;

  prf_write_ctrl #(
    .DEPTH(DEPTH), .INDEX(INDEX), .WIDTH(WIDTH),
    .FIFO_DEPTH(FD), .INIT_VALUE(INIT_V)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .wb(wb),
    .reinit_i(reinit_i),
    .init_done_o(init_done_o),
    .fifo_count_o(fifo_count_o),
    .rd_addr_i(rd_addr_i),
    .rd_hit_o(rd_hit_o),
    .rd_data_o(rd_data_o),
    .addrwr_o(addrwr_o),
    .datawr_o(datawr_o),
    .we_o(we_o)
  );

  logic [WIDTH-1:0] ram [DEPTH];
  always @(posedge clk) if (we_o) ram[addrwr_o] <= datawr_o;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [INDEX-1:0] a;
    logic [WIDTH-1:0] d;
  } wr_t;

  wr_t              q[$];
  bit               m_init;
  int               m_ptr;
  bit               m_pend;
  logic [WIDTH-1:0] m_prf [DEPTH];

  task automatic model_reset();
    q.delete();
    m_init = 1'b1;
    m_ptr  = 0;
    m_pend = 1'b0;
  endtask

  // One cycle: drive at negedge, check, then advance model at posedge.
  task automatic step(input bit v, input logic [INDEX-1:0] a,
                      input logic [WIDTH-1:0] d, input bit ri,
                      input logic [INDEX-1:0] ra);
    bit               e_we, e_rdy, e_done, e_hit, do_push;
    logic [INDEX-1:0] e_addr;
    logic [WIDTH-1:0] e_data, e_rdata;
    wb.wb_valid_i = v;
    wb.wb_addr_i  = a;
    wb.wb_data_i  = d;
    reinit_i      = ri;
    rd_addr_i     = ra;
    #1;
    e_we = 0; e_addr = '0; e_data = '0; e_hit = 0; e_rdata = '0;
    e_rdy  = reset_n && (q.size() < FD) && !m_pend;
    e_done = reset_n && !m_init;
    if (reset_n) begin
      if (m_init) begin
        e_we = 1; e_addr = INDEX'(m_ptr); e_data = INIT_V;
      end else if (q.size() > 0) begin
        e_we = 1; e_addr = q[0].a; e_data = q[0].d;
      end
    end
    foreach (q[i]) if (q[i].a == ra) begin
      e_hit = 1; e_rdata = q[i].d;
    end
    chk("we", 32'(we_o), 32'(e_we));
    chk("addrwr", 32'(addrwr_o), 32'(e_addr));
    chk("datawr", 32'(datawr_o), 32'(e_data));
    chk("ready", 32'(wb.wb_ready_o), 32'(e_rdy));
    chk("done", 32'(init_done_o), 32'(e_done));
    chk("count", 32'(fifo_count_o), 32'(q.size()));
    chk("hit", 32'(rd_hit_o), 32'(e_hit));
    chk("rdata", 32'(rd_data_o), 32'(e_rdata));
    do_push = v && e_rdy;
    @(posedge clk);
    if (reset_n) begin
      if (m_init) begin
        m_prf[m_ptr] = INIT_V;
        m_ptr++;
        if (m_ptr == DEPTH) begin m_init = 0; m_ptr = 0; end
      end else begin
        if (q.size() > 0) begin
          m_prf[q[0].a] = q[0].d;
          void'(q.pop_front());
          if (ri) m_pend = 1;
        end else if (m_pend) begin
          m_init = 1; m_ptr = 0; m_pend = 0;
        end else if (ri) m_pend = 1;
      end
      if (do_push) q.push_back('{a: a, d: d});
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic [INDEX-1:0] ra);
    step(0, '0, '0, 0, ra);
  endtask

  task automatic settle();
    int k;
    k = 0;
    while ((m_init || q.size() != 0) && k < 80) begin
      idle(INDEX'($urandom_range(0, DEPTH - 1)));
      k++;
    end
    if (m_init || q.size() != 0) chk("settle_timeout", 1, 0);
  endtask

  task automatic cmp_prf();
    for (int i = 0; i < DEPTH; i++) chk("prf", 32'(ram[i]), 32'(m_prf[i]));
  endtask

  initial begin
    wb.wb_valid_i = 0;
    wb.wb_addr_i  = '0;
    wb.wb_data_i  = '0;
    reinit_i      = 0;
    rd_addr_i     = '0;
    model_reset();
    @(negedge clk);
    idle(4'd0);
    idle(4'd1);
    reset_n = 1'b1;

    // Fill the queue during the sweep, including one rejected push.
    step(1, 4'd5, 8'h11, 0, 4'd5);
    step(1, 4'd6, 8'h22, 0, 4'd5);
    step(1, 4'd5, 8'h33, 0, 4'd5);
    step(1, 4'd9, 8'h44, 0, 4'd5);
    step(1, 4'd7, 8'h99, 0, 4'd5);
    settle();
    cmp_prf();

    step(1, 4'd3, 8'hAA, 0, 4'd3);
    step(1, 4'd3, 8'h55, 0, 4'd3);
    idle(4'd3);
    idle(4'd3);
    chk("prf3", 32'(ram[3]), 32'h55);

    for (int n = 0; n < 800; n++) begin
      step($urandom_range(0, 3) != 0,
           INDEX'($urandom_range(0, 7)),
           WIDTH'($urandom),
           $urandom_range(0, 49) == 0,
           INDEX'($urandom_range(0, 7)));
    end
    settle();
    cmp_prf();

    // Reset in the middle of a sweep with a queued write.
    reset_n = 1'b0;
    model_reset();
    idle(4'd0);
    reset_n = 1'b1;
    step(1, 4'd12, 8'hC3, 0, 4'd12);
    for (int k = 0; k < 20 && m_ptr != 7; k++) idle(4'd12);
    chk("q_before_rst", 32'(fifo_count_o), 32'd1);
    reset_n = 1'b0;
    model_reset();
    idle(4'd12);
    idle(4'd12);
    reset_n = 1'b1;
    settle();
    cmp_prf();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
